// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue_if
// Purpose  : Fetch-side and decode-side handshake bundle for decode_queue.
// Revision : 1.0
// ============================================================================
interface decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  out_cls;
    logic        out_likely;
    logic        out_bd;
    logic        halted;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_cls, out_likely, out_bd, halted
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_cls, out_likely, out_bd, halted
    );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : MIPS instruction buffer with head classification and a halting
//            output stage that tracks branch delay slots.
// Revision : 1.0
// ============================================================================
module decode_queue #(
    parameter int DEPTH     = 4,
    parameter bit LIKELY_EN = 1'b0
) (
    input  logic          clk,
    input  logic          rst_b,
    decode_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] c_ptr_one  = PW'(1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);

    localparam logic [2:0] c_cls_alu_r   = 3'd0;
    localparam logic [2:0] c_cls_alu_i   = 3'd1;
    localparam logic [2:0] c_cls_load    = 3'd2;
    localparam logic [2:0] c_cls_store   = 3'd3;
    localparam logic [2:0] c_cls_branch  = 3'd4;
    localparam logic [2:0] c_cls_jump    = 3'd5;
    localparam logic [2:0] c_cls_syscall = 3'd6;
    localparam logic [2:0] c_cls_illegal = 3'd7;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_inst_q, out_inst_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [2:0]    out_cls_q, out_cls_d;
    logic          out_likely_q, out_likely_d;
    logic          out_bd_q, out_bd_d;
    logic          bd_trk_q, bd_trk_d;

    logic        in_ready;
    logic        push;
    logic        load;
    logic [31:0] head_inst;
    logic [31:0] head_pc;
    logic [5:0]  head_op;
    logic [4:0]  head_rt;
    logic [5:0]  head_funct;
    logic [2:0]  head_cls;
    logic        head_likely;

    // Holding reset low must also withhold in_ready, so it is gated here.
    assign in_ready = rst_b && !bus.flush && (count_q != c_cnt_full);
    assign push     = bus.in_valid && in_ready;
    assign load     = (count_q != '0) && (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);

    assign head_inst  = inst_mem[rd_ptr_q];
    assign head_pc    = pc_mem[rd_ptr_q];
    assign head_op    = head_inst[31:26];
    assign head_rt    = head_inst[20:16];
    assign head_funct = head_inst[5:0];

    always_comb begin : p_classify
        head_cls    = c_cls_illegal;
        head_likely = 1'b0;
        case (head_op)
            6'h00: begin
                case (head_funct)
                    6'h0C:                      head_cls = c_cls_syscall;
                    6'h08, 6'h09:               head_cls = c_cls_jump;
                    6'h00, 6'h02, 6'h03, 6'h04,
                    6'h06, 6'h07, 6'h20, 6'h21,
                    6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: head_cls = c_cls_alu_r;
                    default:                    head_cls = c_cls_illegal;
                endcase
            end
            6'h01: begin
                case (head_rt)
                    5'h00, 5'h01, 5'h10, 5'h11: head_cls = c_cls_branch;
                    5'h02, 5'h03, 5'h12, 5'h13: begin
                        if (LIKELY_EN) begin
                            head_cls    = c_cls_branch;
                            head_likely = 1'b1;
                        end else begin
                            head_cls = c_cls_illegal;
                        end
                    end
                    default:                    head_cls = c_cls_illegal;
                endcase
            end
            6'h02, 6'h03:                       head_cls = c_cls_jump;
            6'h04, 6'h05, 6'h06, 6'h07:         head_cls = c_cls_branch;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:         head_cls = c_cls_alu_i;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:  head_cls = c_cls_load;
            6'h28, 6'h29, 6'h2B:                head_cls = c_cls_store;
            default:                            head_cls = c_cls_illegal;
        endcase
    end

    always_comb begin : p_next
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_cls_d    = out_cls_q;
        out_likely_d = out_likely_q;
        out_bd_d     = out_bd_q;
        bd_trk_d     = bd_trk_q;

        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            state_d     = ST_RUN;
            out_valid_d = 1'b0;
            bd_trk_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (load) begin
                rd_ptr_d     = rd_ptr_q + c_ptr_one;
                out_valid_d  = 1'b1;
                out_inst_d   = head_inst;
                out_pc_d     = head_pc;
                out_cls_d    = head_cls;
                out_likely_d = head_likely;
                // The delay slot flag belongs to whatever follows a control transfer.
                out_bd_d     = bd_trk_q;
                bd_trk_d     = (head_cls == c_cls_branch) || (head_cls == c_cls_jump);
                if ((head_cls == c_cls_syscall) || (head_cls == c_cls_illegal)) begin
                    state_d = ST_HALT;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            case ({push, load})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin : p_state
        if (!rst_b) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_RUN;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            out_cls_q    <= '0;
            out_likely_q <= 1'b0;
            out_bd_q     <= 1'b0;
            bd_trk_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_cls_q    <= out_cls_d;
            out_likely_q <= out_likely_d;
            out_bd_q     <= out_bd_d;
            bd_trk_q     <= bd_trk_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin : p_mem
        if (push) begin
            inst_mem[wr_ptr_q] <= bus.in_inst;
            pc_mem[wr_ptr_q]   <= bus.in_pc;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_inst   = out_inst_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_cls    = out_cls_q;
    assign bus.out_likely = out_likely_q;
    assign bus.out_bd     = out_bd_q;
    assign bus.halted     = (state_q == ST_HALT);
endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Directed and randomized bench for decode_queue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_decode_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    decode_queue_if bus ();
    decode_queue_if bus2 ();

    decode_queue #(.DEPTH(DEPTH), .LIKELY_EN(1'b0)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    decode_queue #(.DEPTH(DEPTH), .LIKELY_EN(1'b1)) dut2 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t        m_fifo[$];
    logic        m_ov;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic [2:0]  m_cls;
    logic        m_likely;
    logic        m_bd;
    logic        m_bdtrk;
    logic        m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction class straight from the opcode tables.
    function automatic void classify(input logic [31:0] w, input bit len,
                                     output logic [2:0] c, output logic lk);
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        op = w[31:26];
        rt = w[20:16];
        fn = w[5:0];
        lk = 1'b0;
        c  = 3'd7;
        if (op == 6'h00) begin
            if (fn == 6'h0C) c = 3'd6;
            else if (fn inside {6'h08, 6'h09}) c = 3'd5;
            else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                [6'h20:6'h27], 6'h2A, 6'h2B}) c = 3'd0;
        end else if (op == 6'h01) begin
            if (rt inside {5'h00, 5'h01, 5'h10, 5'h11}) c = 3'd4;
            else if (rt inside {5'h02, 5'h03, 5'h12, 5'h13} && len) begin
                c  = 3'd4;
                lk = 1'b1;
            end
        end else if (op inside {6'h02, 6'h03}) c = 3'd5;
        else if (op inside {[6'h04:6'h07]}) c = 3'd4;
        else if (op inside {[6'h08:6'h0F]}) c = 3'd1;
        else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) c = 3'd2;
        else if (op inside {6'h28, 6'h29, 6'h2B}) c = 3'd3;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  ops [12];
        logic [5:0]  fns [8];
        ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0F, 6'h20, 6'h23, 6'h25, 6'h28, 6'h2B};
        fns = '{6'h00, 6'h03, 6'h08, 6'h09, 6'h20, 6'h25, 6'h2A, 6'h2B};
        w = $urandom;
        case ($urandom_range(0, 4))
            0: begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 7)]; end
            1: w[31:26] = ops[$urandom_range(0, 11)];
            2: w[31:26] = ops[$urandom_range(0, 11)];
            3: w[31:26] = 6'h01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic m_reset();
        m_fifo.delete();
        m_ov     = 1'b0;
        m_inst   = '0;
        m_pc     = '0;
        m_cls    = '0;
        m_likely = 1'b0;
        m_bd     = 1'b0;
        m_bdtrk  = 1'b0;
        m_halt   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, ".in_ready"},   32'(bus.in_ready),   32'd0);
        chk({tag, ".halted"},     32'(bus.halted),     32'd0);
        chk({tag, ".out_cls"},    32'(bus.out_cls),    32'd0);
        chk({tag, ".out_inst"},   bus.out_inst,        32'd0);
        chk({tag, ".out_pc"},     bus.out_pc,          32'd0);
        chk({tag, ".out_bd"},     32'(bus.out_bd),     32'd0);
        chk({tag, ".out_likely"}, 32'(bus.out_likely), 32'd0);
    endtask

    // One clock: compare against the model, advance the model, take the edge.
    task automatic cycle();
        bit          push;
        bit          load;
        ent_t        e;
        logic [2:0]  c;
        logic        lk;
        #1;
        chk("in_ready",  32'(bus.in_ready),  32'((m_fifo.size() < DEPTH) && !bus.flush));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("halted",    32'(bus.halted),    32'(m_halt));
        if (m_ov) begin
            chk("out_inst",   bus.out_inst,        m_inst);
            chk("out_pc",     bus.out_pc,          m_pc);
            chk("out_cls",    32'(bus.out_cls),    32'(m_cls));
            chk("out_likely", 32'(bus.out_likely), 32'(m_likely));
            chk("out_bd",     32'(bus.out_bd),     32'(m_bd));
        end
        if (bus.flush) begin
            m_fifo.delete();
            m_ov    = 1'b0;
            m_bdtrk = 1'b0;
            m_halt  = 1'b0;
        end else begin
            push = bus.in_valid && (m_fifo.size() < DEPTH);
            load = (m_fifo.size() > 0) && !m_halt && (!m_ov || bus.out_ready);
            if (load) begin
                e = m_fifo.pop_front();
                classify(e.inst, 1'b0, c, lk);
                m_ov     = 1'b1;
                m_inst   = e.inst;
                m_pc     = e.pc;
                m_cls    = c;
                m_likely = lk;
                m_bd     = m_bdtrk;
                m_bdtrk  = (c == 3'd4) || (c == 3'd5);
                if (c >= 3'd6) m_halt = 1'b1;
            end else if (m_ov && bus.out_ready) begin
                m_ov = 1'b0;
            end
            if (push) begin
                e.inst = bus.in_inst;
                e.pc   = bus.in_pc;
                m_fifo.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_inst    = '0;
        bus.in_pc      = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_inst   = '0;
        bus2.in_pc     = '0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk_reset_outputs("por");
        rst_b = 1'b1;
        cycle();

        // Single add with two-cycle latency
        bus.out_ready = 1'b1;
        send(32'h0109_5020, 32'h0040_0000);
        repeat (3) cycle();

        // Fill past capacity with the consumer stalled, then drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'h2008_0000 + 32'(i);
            bus.in_pc    = 32'h0000_1000 + 32'(4 * i);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 3) cycle();

        // Branch followed by its delay slot
        send(32'h1022_0003, 32'h0000_2000);
        send(32'h0000_0000, 32'h0000_2004);
        repeat (3) cycle();

        // Syscall halts; the following add must never appear; flush recovers
        bus.out_ready = 1'b0;
        send(32'h0000_000C, 32'h0000_3000);
        send(32'h0109_5020, 32'h0000_3004);
        repeat (3) cycle();
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        repeat (2) cycle();

        // bltzl is illegal without branch-likely support
        send(32'h0442_0001, 32'h0000_4000);
        repeat (3) cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;

        // bltzl accepted as a likely branch on the second instance
        bus2.in_valid = 1'b1;
        bus2.in_inst  = 32'h0442_0001;
        bus2.in_pc    = 32'h0000_0500;
        cycle();
        bus2.in_valid = 1'b0;
        cycle();
        chk("likely.out_valid",  32'(bus2.out_valid),  32'd1);
        chk("likely.out_cls",    32'(bus2.out_cls),    32'd4);
        chk("likely.out_likely", 32'(bus2.out_likely), 32'd1);
        chk("likely.out_pc",     bus2.out_pc,          32'h0000_0500);
        chk("likely.halted",     32'(bus2.halted),     32'd0);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0) || (m_halt && ($urandom_range(0, 5) == 0));
            bus.in_inst   = rand_inst();
            bus.in_pc     = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        cycle();
        bus.flush = 1'b0;

        // Reset mid-operation with one staged and three buffered entries
        for (int i = 0; i < 4; i++) begin
            send(32'h2129_0000 + 32'(i), 32'h0000_6000 + 32'(4 * i));
        end
        cycle();
        #2;
        rst_b = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        m_reset();
        @(posedge clk);
        #3;
        rst_b         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter LIKELY_EN, default 0; 1 accepts branch-likely REGIMM forms, 0 flags them illegal.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  fetch offers an instruction.
REQ-006 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port in_inst  input  32  MIPS instruction word.
REQ-008 SHALL have port in_pc  input  32  PC of in_inst.
REQ-009 SHALL have port flush  input  1  synchronous discard of all buffered/staged instructions.
REQ-010 SHALL have port out_valid  output  1  out_* holds a decoded instruction.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 SHALL have ports out_inst, out_pc  output  32 each  staged instruction and PC.
REQ-013 SHALL have port out_cls  output  3  class: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 SYSCALL, 7 ILLEGAL.
REQ-014 SHALL have ports out_likely, out_bd, halted  output  1 each  branch-likely, in delay slot, exception halt.

Function
REQ-015 SHALL buffer instructions in a DEPTH-entry circular FIFO (rd/wr pointers, count width clog2(DEPTH+1)).
REQ-016 SHALL assert in_ready iff count<DEPTH and flush=0; push iff in_valid&&in_ready.
REQ-017 SHALL classify FIFO head combinationally from opcode [31:26], rt [20:16], funct [5:0].
REQ-018 SHALL classify op 0: funct 0x0C SYSCALL; 0x08/0x09 JUMP; 0x00,02,03,04,06,07,20-27,2A,2B ALU_R; other ILLEGAL.
REQ-019 SHALL classify op 1: rt 0x00,0x01,0x10,0x11 BRANCH; rt 0x02,0x03,0x12,0x13 BRANCH with likely=1 if LIKELY_EN else ILLEGAL; other ILLEGAL.
REQ-020 SHALL classify op 0x02,0x03 JUMP; 0x04-0x07 BRANCH; 0x08-0x0F ALU_I; 0x20,21,23,24,25 LOAD; 0x28,29,2B STORE; all others ILLEGAL.
REQ-021 SHALL load output stage from FIFO head (pop) when FIFO non-empty, state RUN, and (out_valid=0 or out_ready=1).
REQ-022 SHALL clear out_valid on out_valid&&out_ready with no same-cycle load; out_* otherwise held stable while out_valid&&!out_ready.
REQ-023 SHALL give minimum latency 2 cycles: pushed at edge N, out_valid high after edge N+1.
REQ-024 SHALL sustain one instruction per cycle in and out when neither side stalls; push and pop same cycle leave count unchanged.
REQ-025 SHALL set out_bd=1 on the entry loaded immediately after a BRANCH or JUMP entry, else 0.
REQ-026 SHALL run FSM RUN/HALT: loading class SYSCALL or ILLEGAL moves RUN->HALT; halted=1 in HALT.
REQ-027 SHALL in HALT perform no loads; the excepting entry stays presented until consumed; FIFO keeps accepting until full.
REQ-028 SHALL on flush=1 at an edge: count=0, pointers equal, out_valid=0, bd tracker=0, state RUN; no push that cycle; flush overrides all.
REQ-029 SHALL wrap pointers modulo DEPTH with no loss at full/empty boundary.

Reset
REQ-030 SHALL on rst_b=0 immediately force: out_valid=0, in_ready=0 while asserted, count=0, pointers 0, state RUN, halted=0, out_bd=0, out_likely=0, out_cls=0, out_inst/out_pc=0.
REQ-031 SHALL have in_ready=1 on the first cycle after rst_b deasserts; reset mid-operation discards all contents.

Verification
REQ-032 SHALL cover: push 0x01095020 (add) pc 0x400000, out_ready=1 -> two cycles later out_valid=1, out_cls=0, out_pc=0x400000.
REQ-033 SHALL cover: out_ready=0, push DEPTH+1 words -> in_ready=0 after DEPTH pushes, extra word not accepted; drain -> all DEPTH emerge in order.
REQ-034 SHALL cover: push 0x10220003 (beq) then 0x00000000 (sll) -> beq cls=4 bd=0; sll cls=0 bd=1.
REQ-035 SHALL cover: push 0x0000000C then add -> SYSCALL cls=6, halted=1, add never appears; flush -> halted=0, out_valid=0, count=0.
REQ-036 SHALL cover: 0x04420001 (bltzl) with LIKELY_EN=0 -> cls=7, halted=1; with LIKELY_EN=1 -> cls=4, out_likely=1.
REQ-037 SHALL cover: rst_b pulsed low with 3 entries buffered and out_valid=1 -> outputs at reset values immediately, no stale entry afterwards.
